// File: rtl/pc_redirect_ctrl.sv
// Selects the next PC source and holds redirects that arrive during an I-cache miss
// until the fetch can commit. A halt freezes fetch until reset.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              hz_stall,
  input  logic [31:0]       PC4,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jr_req,
  input  logic [31:0]       jr_target,
  input  logic              j_req,
  input  logic [31:0]       j_target,
  input  logic              halt,
  output logic [31:0]       next_PC,
  output logic              pc_stall,
  output logic              squash,
  output logic              pending,
  output logic              halted,
  output logic [CNT_W-1:0]  redirect_cnt
);

  typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

  state_t             state, state_n;
  logic [31:0]        pend_tgt, pend_tgt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               req;
  logic               commit;
  logic               inc;
  logic [31:0]        raw_tgt;
  logic [31:0]        sel_tgt;

  // Oldest pipeline stage wins; targets are word aligned.
  always_comb begin
    raw_tgt = 32'h0;
    if (br_taken)    raw_tgt = br_target;
    else if (jr_req) raw_tgt = jr_target;
    else if (j_req)  raw_tgt = j_target;
    sel_tgt = raw_tgt & ~32'h3;
  end

  assign req    = br_taken | jr_req | j_req;
  assign commit = ihit & ~hz_stall & (state != HALT);

  // Next-state, pending-target and counter update.
  always_comb begin
    state_n    = state;
    pend_tgt_n = pend_tgt;
    cnt_n      = cnt;
    inc        = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          state_n = HALT;
        end else if (req) begin
          if (commit) begin
            inc = 1'b1;
          end else begin
            pend_tgt_n = sel_tgt;
            state_n    = PEND;
          end
        end
      end
      PEND: begin
        if (halt) begin
          state_n = HALT;
        end else begin
          if (req) pend_tgt_n = sel_tgt;
          if (commit) begin
            inc     = 1'b1;
            state_n = RUN;
          end
        end
      end
      HALT: state_n = HALT;
      default: state_n = RUN;
    endcase
    if (inc && (cnt != {CNT_W{1'b1}})) cnt_n = cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= RUN;
      pend_tgt <= RESET_PC;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      pend_tgt <= pend_tgt_n;
      cnt      <= cnt_n;
    end
  end

  // Zero-latency PC control; reset forces a stalled, unsquashed sequential fetch.
  always_comb begin
    next_PC  = PC4;
    pc_stall = 1'b1;
    squash   = 1'b0;
    if (nRST) begin
      pc_stall = hz_stall | halt | (state == HALT);
      squash   = (req | (state == PEND)) & (state != HALT);
      case (state)
        RUN:     next_PC = req ? sel_tgt : PC4;
        PEND:    next_PC = req ? sel_tgt : pend_tgt;
        default: next_PC = PC4;
      endcase
    end
  end

  assign pending      = nRST & (state == PEND);
  assign halted       = nRST & (state == HALT);
  assign redirect_cnt = cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus random traffic,
// all compared against a behavioural redirect model.
module tb_pc_redirect_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit = 1'b0, hz_stall = 1'b0, halt = 1'b0;
  logic          br_taken = 1'b0, jr_req = 1'b0, j_req = 1'b0;
  logic [31:0]   PC4 = 32'h4, br_target = 32'h0, jr_target = 32'h0, j_target = 32'h0;
  logic [31:0]   next_PC;
  logic          pc_stall, squash, pending, halted;
  logic [CW-1:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Model: is a redirect outstanding, is fetch frozen, where to, how many taken.
  bit            m_pending = 1'b0;
  bit            m_halted  = 1'b0;
  logic [31:0]   m_pend_tgt = 32'h0;
  int            m_cnt = 0;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .CLK(clk), .nRST(nRST), .ihit(ihit), .hz_stall(hz_stall), .PC4(PC4),
    .br_taken(br_taken), .br_target(br_target), .jr_req(jr_req), .jr_target(jr_target),
    .j_req(j_req), .j_target(j_target), .halt(halt),
    .next_PC(next_PC), .pc_stall(pc_stall), .squash(squash), .pending(pending),
    .halted(halted), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_target();
    logic [31:0] t;
    if (br_taken)    t = br_target;
    else if (jr_req) t = jr_target;
    else             t = j_target;
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic [39:0] model_exp();
    bit          rq;
    logic [31:0] npc;
    bit          stl, sq;
    rq  = br_taken | jr_req | j_req;
    if (!nRST || m_halted) npc = PC4;
    else if (rq)           npc = m_target();
    else if (m_pending)    npc = m_pend_tgt;
    else                   npc = PC4;
    stl = !nRST || hz_stall || halt || m_halted;
    sq  = nRST && !m_halted && (rq || m_pending);
    return {npc, stl, sq, nRST & m_pending, nRST & m_halted, CW'(m_cnt)};
  endfunction

  // Model advances on every edge from the inputs held across it.
  always @(posedge clk) begin
    bit rq;
    rq = br_taken | jr_req | j_req;
    if (!nRST) begin
      m_pending = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (halt) begin
      m_halted = 1; m_pending = 0;
    end else if ((rq || m_pending) && ihit && !hz_stall) begin
      m_pending = 0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (rq) begin
      m_pending = 1; m_pend_tgt = m_target();
    end
  end

  function automatic logic [39:0] obs();
    return {next_PC, pc_stall, squash, pending, halted, redirect_cnt};
  endfunction

  task automatic next_edge();
    @(posedge clk); #1;
    PC4 = PC4 + 32'd4;
  endtask

  task automatic clear_reqs();
    br_taken = 0; jr_req = 0; j_req = 0; halt = 0;
  endtask

  task automatic test_reset();
    nRST = 0; br_taken = 1; br_target = 32'h100; ihit = 1;
    for (int i = 0; i < 2; i++) begin
      next_edge();
      @(negedge clk);
      checks++;
      if ({pc_stall, squash, pending, halted, redirect_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}) begin
        errors++;
        $display("FAIL reset_outputs: got stall=%b squash=%b pend=%b halted=%b cnt=%0d, expected 1 0 0 0 0",
                 pc_stall, squash, pending, halted, redirect_cnt);
      end
    end
    next_edge();
    nRST = 1; clear_reqs();
    @(negedge clk);
    checks++;
    if ({next_PC, pending, halted} !== {PC4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got next_PC=%h pend=%b halted=%b, expected %h 0 0",
               next_PC, pending, halted, PC4);
    end
    next_edge();
  endtask

  task automatic test_priority();
    logic [31:0] want [3];
    want[0] = 32'h100; want[1] = 32'h200; want[2] = 32'h300;
    ihit = 1; hz_stall = 0;
    br_target = 32'h100; jr_target = 32'h200; j_target = 32'h303;
    for (int i = 0; i < 3; i++) begin
      br_taken = (i == 0); jr_req = (i <= 1); j_req = 1;
      @(negedge clk);
      checks++;
      if (next_PC !== want[i]) begin
        errors++;
        $display("FAIL priority_%0d: got next_PC=%h, expected %h", i, next_PC, want[i]);
      end
      checks++;
      if (obs() !== model_exp()) begin
        errors++;
        $display("FAIL priority_model_%0d: got %h, expected %h", i, obs(), model_exp());
      end
      next_edge();
    end
    clear_reqs();
  endtask

  task automatic test_miss_redirect();
    int cnt0;
    ihit = 0; hz_stall = 0;
    br_taken = 1; br_target = 32'h40;
    @(negedge clk);
    next_edge();
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({pending, squash, next_PC} !== {1'b1, 1'b1, 32'h40}) begin
        errors++;
        $display("FAIL miss_hold_%0d: got pend=%b squash=%b next_PC=%h, expected 1 1 00000040",
                 i, pending, squash, next_PC);
      end
      next_edge();
    end
    cnt0 = m_cnt;
    ihit = 1;
    @(negedge clk);
    next_edge();
    @(negedge clk);
    checks++;
    if ({pending, redirect_cnt} !== {1'b0, CW'(cnt0 + 1)}) begin
      errors++;
      $display("FAIL miss_commit: got pend=%b cnt=%0d, expected 0 %0d", pending, redirect_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_overwrite();
    int cnt0;
    ihit = 0; br_taken = 1; br_target = 32'h40;
    next_edge();
    clear_reqs();
    jr_req = 1; jr_target = 32'h80;
    @(negedge clk);
    checks++;
    if (next_PC !== 32'h80) begin
      errors++;
      $display("FAIL overwrite_same_cycle: got next_PC=%h, expected 00000080", next_PC);
    end
    next_edge();
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({pending, next_PC} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL overwrite_held: got pend=%b next_PC=%h, expected 1 00000080", pending, next_PC);
    end
    cnt0 = m_cnt;
    next_edge();
    ihit = 1;
    next_edge();
    @(negedge clk);
    checks++;
    if ({pending, redirect_cnt} !== {1'b0, CW'(cnt0 + 1)}) begin
      errors++;
      $display("FAIL overwrite_commit: got pend=%b cnt=%0d, expected 0 %0d", pending, redirect_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_halt();
    int cnt0;
    next_edge();
    ihit = 0; br_taken = 1; br_target = 32'h48;
    next_edge();
    cnt0 = m_cnt;
    halt = 1; br_taken = 1; ihit = 1;
    @(negedge clk);
    checks++;
    if (pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL halt_stall: got pc_stall=%b, expected 1", pc_stall);
    end
    next_edge();
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({halted, pending, redirect_cnt} !== {1'b1, 1'b0, CW'(cnt0)}) begin
      errors++;
      $display("FAIL halt_enter: got halted=%b pend=%b cnt=%0d, expected 1 0 %0d",
               halted, pending, redirect_cnt, cnt0);
    end
    for (int i = 0; i < 6; i++) begin
      next_edge();
      br_taken = 1'($urandom); jr_req = 1'($urandom); j_req = 1'($urandom);
      br_target = $urandom; jr_target = $urandom; j_target = $urandom;
      @(negedge clk);
      checks++;
      if ({next_PC, pc_stall, squash, halted, redirect_cnt} !== {PC4, 1'b1, 1'b0, 1'b1, CW'(cnt0)}) begin
        errors++;
        $display("FAIL halt_ignore_%0d: got next_PC=%h stall=%b squash=%b halted=%b cnt=%0d",
                 i, next_PC, pc_stall, squash, halted, redirect_cnt);
      end
    end
    next_edge();
    clear_reqs();
    nRST = 0;
    next_edge();
    nRST = 1;
    @(negedge clk);
    checks++;
    if ({halted, pending, next_PC} !== {1'b0, 1'b0, PC4}) begin
      errors++;
      $display("FAIL halt_reset_exit: got halted=%b pend=%b next_PC=%h, expected 0 0 %h",
               halted, pending, next_PC, PC4);
    end
    next_edge();
  endtask

  task automatic test_saturation();
    ihit = 1; hz_stall = 0;
    for (int i = 0; i < 17; i++) begin
      br_taken = 1; br_target = $urandom;
      next_edge();
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (redirect_cnt !== 4'hF) begin
      errors++;
      $display("FAIL saturation: got cnt=%h, expected f", redirect_cnt);
    end
    next_edge();
  endtask

  task automatic test_random();
    nRST = 0;
    next_edge();
    for (int i = 0; i < 400; i++) begin
      nRST      = ($urandom_range(0, 49) != 0);
      ihit      = ($urandom_range(0, 2) != 0);
      hz_stall  = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      jr_req    = ($urandom_range(0, 5) == 0);
      j_req     = ($urandom_range(0, 4) == 0);
      halt      = ($urandom_range(0, 59) == 0);
      br_target = $urandom; jr_target = $urandom; j_target = $urandom;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) begin
        errors++;
        $display("FAIL random_%0d: got %h, expected %h", i, obs(), model_exp());
      end
      next_edge();
    end
    nRST = 1;
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_miss_redirect();
    test_overwrite();
    test_halt();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencer for the program counter in the pipelined core. Each cycle it chooses the `next_PC` source: sequential PC4, a branch, a jump-register, a jump, or a latched pending redirect. It drives the counter's `stall` input. A redirect that arrives while the instruction cache is missing is held until the fetch can commit, and a halt freezes fetch permanently until reset.

## Interface
- `RESET_PC`, default `32'h0000_0000`: value loaded into the pending-target register at reset.
- `CNT_W`, default `16`: width of the redirect performance counter.

- `CLK` in 1: clock, all state updates on the rising edge.
- `nRST` in 1: reset, synchronous and active-low.
- `ihit` in 1: instruction cache hit. The PC advances only when `ihit & ~pc_stall`.
- `hz_stall` in 1: stall from the hazard unit or the data cache.
- `PC4` in 32: sequential successor from the program counter.
- `br_taken` in 1: branch resolved taken (MEM stage).
- `br_target` in 32: branch target.
- `jr_req` in 1: jump-register (EX stage).
- `jr_target` in 32: register target.
- `j_req` in 1: jump (ID stage).
- `j_target` in 32: jump target.
- `halt` in 1: halt instruction reached MEM.
- `next_PC` out 32: value the program counter loads on commit.
- `pc_stall` out 1: drives the program counter's `stall` input.
- `squash` out 1: flush IF/ID (insert a bubble).
- `pending` out 1: a redirect is latched and not yet committed.
- `halted` out 1: fetch is permanently frozen.
- `redirect_cnt` out `CNT_W`: number of committed redirects, saturating.

## Operation
- **Request:** `req = br_taken | jr_req | j_req`.
- **Priority:** branch > jr > jump. The oldest pipeline stage wins.
- **Selected target:** `sel_tgt`, with bits [1:0] forced to `2'b00`.
- **Commit condition:** `commit = ihit & ~hz_stall & (state != HALT)`.

States:
- **RUN**
  - `next_PC` = `sel_tgt` if `req`, else `PC4`.
  - `req & commit`: stay in RUN and increment the counter.
  - `req & ~commit`: `pend_tgt <= sel_tgt`, go to PEND.
- **PEND**
  - `next_PC = pend_tgt`; `pending = 1`.
  - A new `req` in PEND overwrites `pend_tgt` with `sel_tgt`, and `next_PC` shows `sel_tgt` that same cycle.
  - `commit`: go to RUN and increment the counter. Counts once per commit, not once per overwrite.
- **HALT**
  - `halted = 1`, `pc_stall = 1`, `next_PC = PC4`.
  - Ignores all requests. Only reset exits.

Halt handling:
- `halt` in RUN or PEND: go to HALT next cycle.
- In the `halt` cycle, `pc_stall = 1` and no commit or counter increment occurs.
- Any pending target is discarded.
- `halt` has priority over a simultaneous `req`.

Outputs:
- `pc_stall = hz_stall | halt | (state == HALT)`.
- `squash = (req | state == PEND) & ~(state == HALT)`.

Counter:
- `redirect_cnt` increments on each commit of a redirect.
- It saturates at all-ones and never wraps.

## Timing
- **Reset:** with `nRST = 0` at a rising edge, the next state is RUN, `pend_tgt = RESET_PC`, and `redirect_cnt = 0`.
- **During the reset cycle**, outputs are forced:
  - `pc_stall = 1`, `squash = 0`, `pending = 0`, `halted = 0`.
  - `next_PC = PC4`.
- **Reset mid-operation:** reset in PEND or HALT drops the pending target or halt. There is no commit on that edge.
- **Output paths:** `next_PC`, `pc_stall` and `squash` are combinational from the registered state and current inputs, with zero-cycle latency. `pending`, `halted` and `redirect_cnt` are registered.
- **Redirect hitting immediately:** the PC holds the target after 1 edge. `squash` is high for 1 cycle.
- **Redirect during a miss of N cycles:** `squash` and `pending` stay high for N cycles. The PC loads the target on the first `ihit & ~hz_stall` edge.
- **`ihit` with `hz_stall = 1` in PEND:** no commit; stay in PEND.

## Test plan
- **Reset:** hold `nRST = 0` 2 cycles with `br_taken = 1`.
  - Expect `pc_stall = 1`, `squash = 0`, `redirect_cnt = 0`.
  - After release, expect RUN and `next_PC = PC4`.
- **Priority:** `br_taken`, `jr_req` and `j_req` all high, with targets `0x100`, `0x200` and `0x303`.
  - Expect `next_PC = 0x100`.
  - With `jr_req` and `j_req` only, expect `0x200`.
  - With `j_req` alone, expect `0x300` (alignment mask applied).
- **Miss then redirect:** `ihit = 0`, then a 1-cycle `br_taken` pulse with target `0x40`.
  - Expect `pending = 1` and `next_PC = 0x40` for 3 miss cycles.
  - Then `ihit = 1`: commit, `pending = 0`, `redirect_cnt = 1`.
- **Overwrite in PEND:** while pending `0x40`, pulse `jr_req` with target `0x80`.
  - Expect `next_PC = 0x80`.
  - Commit on `ihit`: `redirect_cnt` increases by exactly 1.
- **Halt:** `halt = 1` in PEND together with `br_taken`.
  - Expect `pc_stall = 1` and no commit.
  - Next cycle `halted = 1` and `pending = 0`.
  - Later requests are ignored. `nRST = 0` returns to RUN.
- **Saturation:** with `CNT_W = 4`, commit 17 redirects.
  - Expect `redirect_cnt = 4'hF`.
